axi_lite_gpio_regs: RTL
=======================

AXI_LITE_GPIO_REGS -- requirements
Module: axi_lite_gpio_regs

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, the AXI ID width carried through from awid/arid to bid/rid.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, the byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, the data width; legal values are 32 and 64.
REQ-004 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, the write-strobe width.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; the interface instance is clocked by the same net.
REQ-006 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port s_axi, axi_lite_if slave side: the AXI-Lite subordinate port (aw/w/b/ar/r channels).
REQ-008 SHALL have port leds, output, 8 bits: board LED drive.
REQ-009 SHALL have port sw, input, 8 bits: asynchronous slide switches.
REQ-010 SHALL have port btn, input, 5 bits: asynchronous push buttons.

Function
REQ-011 SHALL implement a register map on addr[5:3] with addr[2:0] ignored:
- 0x00 LED: RW, bits[7:0], upper bits read 0.
- 0x08 SW: RO, synchronized switches.
- 0x10 BTN_LEVEL: RO, synchronized buttons.
- 0x18 BTN_EVENT: sticky rising-edge flags, write-1-to-clear.
- 0x20 SCRATCH: RW, full DATA_WIDTH.
REQ-012 SHALL respond DECERR (3) on any access where the address is above 0x27 or any bit above bit 5 is set; a DECERR read returns rdata 0, and a DECERR write has no effect.
REQ-013 SHALL respond SLVERR (2) to writes to SW or BTN_LEVEL, with no state change; all other accesses SHALL respond OKAY (0).
REQ-014 SHALL pass each sw and btn bit through a 2-flop synchronizer before use; edge detection SHALL compare the synchronized value with its value one cycle earlier.
REQ-015 SHALL apply byte lanes according to wstrb: LED uses wstrb[0]; SCRATCH updates byte i only when wstrb[i]=1; BTN_EVENT clear is qualified by wstrb[0].
REQ-016 When a button rise and a W1C to the same flag occur in the same cycle, the set SHALL win.
REQ-017 Write path:
- awready is high when no address is held and bvalid=0; wready is high when no data is held and bvalid=0.
- AW and W are captured independently, in either order.
- In the cycle after both are held, the register update is committed and bvalid asserts, with bid equal to the captured awid.
REQ-018 bvalid SHALL remain high with bid and bresp stable until bready=1; on the accepting edge, the held address and data SHALL be released.
REQ-019 Write latency SHALL be: AW and W accepted in cycle N gives bvalid in cycle N+1; W accepted k cycles after AW gives bvalid one cycle after W is accepted.
REQ-020 Read path:
- arready equals !rvalid, with one read outstanding at a time.
- arvalid&&arready in cycle N gives registered rvalid/rdata/rresp/rid in cycle N+1.
- rdata holds stable until rready=1.
REQ-021 A read and a write to the same register in the same cycle SHALL return the pre-write value.
REQ-022 leds SHALL be driven directly from the LED register bits[7:0].

Reset
REQ-023 While areset=1 at a clock edge:
- awready, wready, arready, bvalid and rvalid SHALL be 0.
- The LED, SCRATCH and BTN_EVENT registers and all synchronizer stages SHALL be 0, and leds=0.
- bresp, rresp, bid, rid and rdata SHALL be 0.
REQ-024 The ready signals SHALL rise in the first cycle after areset deasserts.
REQ-025 Reset asserted mid-transaction SHALL abort it: held AW/W and pending B/R responses SHALL be discarded, with no partial register update.

Structure
REQ-026 Response codes (OKAY, EXOKAY, SLVERR, DECERR) SHALL be an enum in the shared axi_lite_pkg; register offsets SHALL be localparams in gpio_regs_pkg.
REQ-027 The synchronizer SHALL be a sub-module sync_2ff, parameterized by width, instantiated once for sw and once for btn.

Verification
REQ-028 Write LED=0xA5 with wstrb=0x01 and AW/W in the same cycle -> bvalid next cycle, bresp=0, leds=0xA5; a subsequent read of 0x00 returns 0xA5.
REQ-029 Send W (SCRATCH data 0x1122334455667788, wstrb=0x0F) 3 cycles before AW to 0x20 -> bvalid one cycle after AW is accepted; readback is 0x0000000055667788.
REQ-030 Pulse btn[2] 0->1 and hold -> BTN_EVENT reads 0x04 after the synchronizer delay; writing 0x04 to 0x18 clears it; a clear coinciding with a new rise leaves 0x04 set.
REQ-031 Read 0x40 returns rresp=3, rdata=0; write 0x08 returns bresp=2 and the SW register is unchanged.
REQ-032 Hold bready=0 for 5 cycles -> bvalid, bid and bresp stay stable, and awready and wready stay 0 throughout.
REQ-033 Assert areset while bvalid=1 -> bvalid=0 and all registers are 0 next cycle; awready=1 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions used by every subordinate in the codebase.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

endpackage

// File: rtl/gpio_regs_pkg.sv
// Register map of the GPIO block; offsets are 8-byte aligned, decoded on addr[5:3].
package gpio_regs_pkg;

  localparam logic [5:0] OFF_LED       = 6'h00;
  localparam logic [5:0] OFF_SW        = 6'h08;
  localparam logic [5:0] OFF_BTN_LEVEL = 6'h10;
  localparam logic [5:0] OFF_BTN_EVENT = 6'h18;
  localparam logic [5:0] OFF_SCRATCH   = 6'h20;

  localparam int unsigned NUM_SW  = 8;
  localparam int unsigned NUM_BTN = 5;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle (aw/w/b/ar/r) with manager and subordinate views.
interface axi_lite_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input logic aclk
);

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    input  aclk,
    output awid, awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arvalid, input arready,
    input  rid, rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk,
    input  awid, awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arvalid, output arready,
    output rid, rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, one chain per bit.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/axi_lite_gpio_regs.sv
// AXI-Lite GPIO register block: LEDs, switches, buttons with sticky W1C edge flags, scratch.
module axi_lite_gpio_regs
  import axi_lite_pkg::*;
  import gpio_regs_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic               aclk,
  input  logic               areset,
  axi_lite_if.slave          s_axi,
  output logic [7:0]         leds,
  input  logic [NUM_SW-1:0]  sw,
  input  logic [NUM_BTN-1:0] btn
);

  logic [NUM_SW-1:0]  sw_s;
  logic [NUM_BTN-1:0] btn_s, btn_prev, btn_rise, btn_clr, btn_evt;

  sync_2ff #(.WIDTH(NUM_SW))  u_sw_sync  (.clk(aclk), .rst(areset), .d(sw),  .q(sw_s));
  sync_2ff #(.WIDTH(NUM_BTN)) u_btn_sync (.clk(aclk), .rst(areset), .d(btn), .q(btn_s));

  logic                  rdy_en, aw_held, w_held, bvalid, rvalid;
  logic [ADDR_WIDTH-1:0] aw_addr, wr_addr;
  logic [ID_WIDTH-1:0]   aw_id, wr_id, bid, rid;
  logic [DATA_WIDTH-1:0] w_data, wr_data, scratch, rdata, rd_data;
  logic [STRB_WIDTH-1:0] w_strb, wr_strb;
  logic [7:0]            led;
  resp_t                 bresp, rresp, wr_resp, rd_resp;
  logic                  awready, wready, arready, aw_take, w_take, commit;

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1:6] != '0) || (a[5:3] > 3'd4);
  endfunction

  function automatic logic [5:0] reg_off(input logic [ADDR_WIDTH-1:0] a);
    return {a[5:3], 3'b000};
  endfunction

  assign awready  = rdy_en && !aw_held && !bvalid;
  assign wready   = rdy_en && !w_held && !bvalid;
  assign arready  = rdy_en && !rvalid;
  assign aw_take  = s_axi.awvalid && awready;
  assign w_take   = s_axi.wvalid && wready;
  assign btn_rise = btn_s & ~btn_prev;

  // Commit on the same edge the last of AW/W arrives, using the incoming beat if not yet held.
  always_comb begin
    wr_addr = aw_held ? aw_addr : s_axi.awaddr;
    wr_id   = aw_held ? aw_id   : s_axi.awid;
    wr_data = w_held  ? w_data  : s_axi.wdata;
    wr_strb = w_held  ? w_strb  : s_axi.wstrb;
    commit  = (aw_held || aw_take) && (w_held || w_take) && !bvalid;
    wr_resp = RESP_OKAY;
    if (addr_bad(wr_addr))
      wr_resp = RESP_DECERR;
    else if (reg_off(wr_addr) == OFF_SW || reg_off(wr_addr) == OFF_BTN_LEVEL)
      wr_resp = RESP_SLVERR;
    btn_clr = '0;
    if (commit && wr_resp == RESP_OKAY && reg_off(wr_addr) == OFF_BTN_EVENT && wr_strb[0])
      btn_clr = wr_data[NUM_BTN-1:0];
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (addr_bad(s_axi.araddr)) begin
      rd_resp = RESP_DECERR;
    end else begin
      case (reg_off(s_axi.araddr))
        OFF_LED:       rd_data[7:0]         = led;
        OFF_SW:        rd_data[NUM_SW-1:0]  = sw_s;
        OFF_BTN_LEVEL: rd_data[NUM_BTN-1:0] = btn_s;
        OFF_BTN_EVENT: rd_data[NUM_BTN-1:0] = btn_evt;
        OFF_SCRATCH:   rd_data              = scratch;
        default:       rd_data              = '0;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rdy_en   <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      aw_id    <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
      rvalid   <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      led      <= '0;
      scratch  <= '0;
      btn_prev <= '0;
      btn_evt  <= '0;
    end else begin
      rdy_en   <= 1'b1;
      btn_prev <= btn_s;
      // Set wins over a coincident clear.
      btn_evt  <= (btn_evt & ~btn_clr) | btn_rise;

      if (aw_take) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi.awaddr;
        aw_id   <= s_axi.awid;
      end
      if (w_take) begin
        w_held <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (commit) begin
        aw_held <= 1'b1;
        w_held  <= 1'b1;
        bvalid  <= 1'b1;
        bid     <= wr_id;
        bresp   <= wr_resp;
        if (wr_resp == RESP_OKAY) begin
          case (reg_off(wr_addr))
            OFF_LED: if (wr_strb[0]) led <= wr_data[7:0];
            OFF_SCRATCH:
              for (int unsigned i = 0; i < STRB_WIDTH; i++)
                if (wr_strb[i]) scratch[8*i +: 8] <= wr_data[8*i +: 8];
            default: ;
          endcase
        end
      end
      if (bvalid && s_axi.bready) begin
        bvalid  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end

      if (s_axi.arvalid && arready) begin
        rvalid <= 1'b1;
        rid    <= s_axi.arid;
        rdata  <= rd_data;
        rresp  <= rd_resp;
      end else if (rvalid && s_axi.rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bid     = bid;
  assign s_axi.bresp   = bresp;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rid     = rid;
  assign s_axi.rdata   = rdata;
  assign s_axi.rresp   = rresp;
  assign leds          = led;

  logic unused;
  assign unused = ^{s_axi.aclk, wr_addr[2:0], s_axi.araddr[2:0]};

endmodule
